// File: rtl/pcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_pkg
//  Description : Shared definitions for the PCM blocks: serializer state
//                encoding and the default PCM word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcm_pkg;

  // Default PCM word width used by the encoder / serializer family.
  localparam int c_pcm_width_default = 8;

  // Serializer frame state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } pcm_state_e;

endpackage : pcm_pkg
`default_nettype wire

// File: rtl/pcm_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_shift_reg
//  Description : Loadable shift register for the PCM serializer. The bit that
//                goes on the line at load time is presented on first_bit and is
//                not stored; the register keeps the remaining bits with the
//                next one to leave at its head (ser_out).
//  Revision    : 1.0 - initial release
// ============================================================================
module pcm_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             first_bit,
  output logic             ser_out
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_shift_val;

  // Bit ordering is fixed at elaboration: MSB-first shifts left, LSB-first
  // shifts right. Vacated positions fill with zero and are never sent.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign first_bit   = din[WIDTH-1];
      assign w_load_val  = {din[WIDTH-2:0], 1'b0};
      assign w_shift_val = {r_data[WIDTH-2:0], 1'b0};
      assign ser_out     = r_data[WIDTH-1];
    end else begin : g_lsb_first
      assign first_bit   = din[0];
      assign w_load_val  = {1'b0, din[WIDTH-1:1]};
      assign w_shift_val = {1'b0, r_data[WIDTH-1:1]};
      assign ser_out     = r_data[0];
    end
  endgenerate

  // Load takes priority over shift; the controller never asserts both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= w_load_val;
    end else if (shift) begin
      r_data <= w_shift_val;
    end
  end

endmodule : pcm_shift_reg
`default_nettype wire

// File: rtl/pcm_par2ser.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_par2ser
//  Description : Parallel-to-serial PCM converter. Accepts WIDTH-bit words on
//                a valid/ready handshake into a one-word holding buffer and
//                serialises them at the bit_en rate, with a sync pulse on the
//                first bit of each frame and GAP idle bits between frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcm_par2ser
  import pcm_pkg::*;
#(
  parameter int WIDTH      = c_pcm_width_default,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP        = 0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic [WIDTH-1:0] in_pcm,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_pcm,
  output logic             out_sync,
  output logic             out_valid,
  output logic             busy
);

  localparam int c_bw = $clog2(WIDTH);
  localparam int c_gw = ($clog2(GAP + 1) > 1) ? $clog2(GAP + 1) : 1;

  localparam logic [c_bw-1:0] c_bit_last = c_bw'(WIDTH - 1);
  localparam logic [c_gw-1:0] c_gap_last = c_gw'((GAP > 0) ? (GAP - 1) : 0);

  // Holding buffer
  logic [WIDTH-1:0] r_hold_data;
  logic             r_hold_full;
  logic             w_accept;

  // Frame controller
  pcm_state_e       r_state;
  pcm_state_e       w_state_nxt;
  logic [c_bw-1:0]  r_bit_cnt;
  logic [c_bw-1:0]  w_bit_cnt_nxt;
  logic [c_gw-1:0]  r_gap_cnt;
  logic [c_gw-1:0]  w_gap_cnt_nxt;
  logic             r_out_pcm;
  logic             w_out_pcm_nxt;
  logic             r_out_sync;
  logic             w_out_sync_nxt;
  logic             r_out_valid;
  logic             w_out_valid_nxt;
  logic             w_load;
  logic             w_shift;
  logic             w_frame_end;

  // Shifter taps
  logic             w_first_bit;
  logic             w_ser_out;

  assign w_accept  = in_valid && !r_hold_full;
  assign in_ready  = !r_hold_full;
  assign out_pcm   = r_out_pcm;
  assign out_sync  = r_out_sync;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != ST_IDLE) || r_hold_full;

  pcm_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .shift     (w_shift),
    .din       (r_hold_data),
    .first_bit (w_first_bit),
    .ser_out   (w_ser_out)
  );

  // Holding buffer: accept is independent of bit_en; a load into the shifter
  // empties it. Load needs full and accept needs empty, so they never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= in_pcm;
    end
  end

  // Frame state, counters and registered line outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_out_pcm   <= IDLE_LEVEL;
      r_out_sync  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_out_pcm   <= w_out_pcm_nxt;
      r_out_sync  <= w_out_sync_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Next-state logic. Everything advances only on a strobe; IDLE, the last
  // data bit (when GAP=0) and the last gap bit share one "frame boundary"
  // decision: start the buffered word if there is one, else go idle.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_out_pcm_nxt   = r_out_pcm;
    w_out_sync_nxt  = r_out_sync;
    w_out_valid_nxt = r_out_valid;
    w_load          = 1'b0;
    w_shift         = 1'b0;
    w_frame_end     = 1'b0;

    if (bit_en) begin
      case (r_state)
        ST_IDLE: begin
          w_frame_end = 1'b1;
        end
        ST_SHIFT: begin
          if (r_bit_cnt == c_bit_last) begin
            if (GAP > 0) begin
              w_state_nxt     = ST_GAP;
              w_gap_cnt_nxt   = '0;
              w_out_pcm_nxt   = IDLE_LEVEL;
              w_out_sync_nxt  = 1'b0;
              w_out_valid_nxt = 1'b0;
            end else begin
              w_frame_end = 1'b1;
            end
          end else begin
            w_shift        = 1'b1;
            w_out_pcm_nxt  = w_ser_out;
            w_out_sync_nxt = 1'b0;
            w_bit_cnt_nxt  = r_bit_cnt + c_bw'(1);
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            w_frame_end = 1'b1;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + c_gw'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase

      if (w_frame_end) begin
        if (r_hold_full) begin
          w_load          = 1'b1;
          w_state_nxt     = ST_SHIFT;
          w_bit_cnt_nxt   = '0;
          w_out_pcm_nxt   = w_first_bit;
          w_out_sync_nxt  = 1'b1;
          w_out_valid_nxt = 1'b1;
        end else begin
          w_state_nxt     = ST_IDLE;
          w_out_pcm_nxt   = IDLE_LEVEL;
          w_out_sync_nxt  = 1'b0;
          w_out_valid_nxt = 1'b0;
        end
      end
    end
  end

endmodule : pcm_par2ser
`default_nettype wire

// File: tb/tb_pcm_par2ser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcm_par2ser
//  Description : Self-checking bench for pcm_par2ser. Two instances:
//                dut0 = MSB-first, no gap, idle 0; dut1 = LSB-first, GAP=2,
//                idle 1. A frame-level model predicts every output each cycle;
//                directed tests add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcm_par2ser;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic [1:0]        be;
  logic [1:0]        v;
  logic [1:0][W-1:0] pcm;
  logic [1:0]        o_ready, o_pcm, o_sync, o_valid, o_busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pcm_par2ser #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bit_en(be[0]), .in_pcm(pcm[0]), .in_valid(v[0]),
    .in_ready(o_ready[0]), .out_pcm(o_pcm[0]), .out_sync(o_sync[0]),
    .out_valid(o_valid[0]), .busy(o_busy[0]));

  pcm_par2ser #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(2), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bit_en(be[1]), .in_pcm(pcm[1]), .in_valid(v[1]),
    .in_ready(o_ready[1]), .out_pcm(o_pcm[1]), .out_sync(o_sync[1]),
    .out_valid(o_valid[1]), .busy(o_busy[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model parameters per instance ----------------
  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction
  function automatic logic msb_of(input int d);
    return (d == 0);
  endfunction
  function automatic logic idle_of(input int d);
    return (d == 1);
  endfunction

  // ---------------- frame-level model ----------------
  // A frame is WIDTH+GAP symbol periods; m_idx is the symbol on the line.
  logic [1:0]        m_active    = '0;
  logic [1:0]        m_hold_full = '0;
  logic [1:0][W-1:0] m_word      = '0;
  logic [1:0][W-1:0] m_hold      = '0;
  int                m_idx [2]   = '{0, 0};
  logic [1:0]        e_pcm = '0, e_sync = '0, e_valid = '0;
  logic              m_acc;

  task automatic model_outputs(input int d);
    if (m_active[d] && m_idx[d] < W) begin
      e_valid[d] = 1'b1;
      e_sync[d]  = (m_idx[d] == 0);
      e_pcm[d]   = msb_of(d) ? m_word[d][W-1-m_idx[d]] : m_word[d][m_idx[d]];
    end else begin
      e_valid[d] = 1'b0;
      e_sync[d]  = 1'b0;
      e_pcm[d]   = idle_of(d);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_active[d]    = 1'b0;
        m_hold_full[d] = 1'b0;
        m_idx[d]       = 0;
      end else begin
        m_acc = v[d] && !m_hold_full[d];
        if (be[d]) begin
          if (m_active[d] && (m_idx[d] + 1 < W + gap_of(d))) begin
            m_idx[d] = m_idx[d] + 1;
          end else if (m_hold_full[d]) begin
            m_word[d]      = m_hold[d];
            m_hold_full[d] = 1'b0;
            m_idx[d]       = 0;
            m_active[d]    = 1'b1;
          end else begin
            m_active[d] = 1'b0;
          end
        end
        if (m_acc) begin
          m_hold_full[d] = 1'b1;
          m_hold[d]      = pcm[d];
        end
      end
      model_outputs(d);
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d out_pcm", d),   o_pcm[d],   e_pcm[d]);
      check($sformatf("dut%0d out_sync", d),  o_sync[d],  e_sync[d]);
      check($sformatf("dut%0d out_valid", d), o_valid[d], e_valid[d]);
      check($sformatf("dut%0d in_ready", d),  o_ready[d], !m_hold_full[d]);
      check($sformatf("dut%0d busy", d),      o_busy[d],  m_active[d] || m_hold_full[d]);
    end
  end

  // ---------------- output collectors ----------------
  logic [1:0][63:0] vbits = '0, vsync = '0, lbits = '0, lval = '0;
  int vcnt [2] = '{0, 0};
  int bcnt [2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      lbits[d] = {lbits[d][62:0], o_pcm[d]};
      lval[d]  = {lval[d][62:0], o_valid[d]};
      if (o_valid[d]) begin
        vbits[d] = {vbits[d][62:0], o_pcm[d]};
        vsync[d] = {vsync[d][62:0], o_sync[d]};
        vcnt[d]++;
      end
      if (o_busy[d]) bcnt[d]++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer a word and return #1 after the accepting edge.
  task automatic send(input int d, input logic [W-1:0] w, input bit keep_valid);
    int n;
    n = 0;
    pcm[d] = w;
    v[d]   = 1'b1;
    while (!o_ready[d] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_err++;
      $display("FAIL send timeout dut%0d: in_ready stayed 0, required 1", d);
    end
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      v[d]   = 1'b0;
      pcm[d] = ~w;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " out_pcm0"},  o_pcm[0],  1'b0);
    check({tag, " out_pcm1"},  o_pcm[1],  1'b1);
    check({tag, " out_valid"}, o_valid,   2'b00);
    check({tag, " out_sync"},  o_sync,    2'b00);
    check({tag, " in_ready"},  o_ready,   2'b11);
    check({tag, " busy"},      o_busy,    2'b00);
  endtask

  logic [W-1:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  int b0, b1, bb;

  initial begin
    be  = 2'b11;
    v   = 2'b00;
    pcm = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick(2);

    // Reset while idle, checked right after assertion.
    #2 reset = 1'b1;
    #1 check_reset("idle reset");
    @(posedge clk);
    #1 reset = 1'b0;
    tick(2);

    // Single word A5, MSB first.
    b0 = vcnt[0];
    send(0, 8'hA5, 1'b0);
    tick(12);
    check("t2 valid cycles", vcnt[0] - b0, 8);
    check("t2 bits", vbits[0][7:0], 8'hA5);
    check("t2 sync", vsync[0][7:0], 8'h80);

    // Back-to-back A5, 3C.
    b0 = vcnt[0];
    send(0, 8'hA5, 1'b0);
    send(0, 8'h3C, 1'b0);
    check("t3 in_ready after 2nd accept", o_ready[0], 1'b0);
    tick(20);
    check("t3 valid cycles", vcnt[0] - b0, 16);
    check("t3 bits", vbits[0][15:0], 16'hA53C);
    check("t3 sync", vsync[0][15:0], 16'h8080);

    // Strobe one cycle in four, word C3: each bit held 4 cycles.
    b0 = vcnt[0];
    fork
      send(0, 8'hC3, 1'b0);
      begin
        for (int i = 0; i < 48; i++) begin
          be[0] = (i % 4 == 0);
          @(posedge clk);
          #1;
        end
        be[0] = 1'b1;
      end
    join
    tick(4);
    check("t4 valid cycles", vcnt[0] - b0, 32);
    check("t4 bits", vbits[0][31:0], 32'hFF0000FF);
    check("t4 sync", vsync[0][31:0], 32'hF0000000);

    // LSB first, GAP=2, idle level 1: words 01 then 80.
    b1 = vcnt[1];
    send(1, 8'h01, 1'b0);
    send(1, 8'h80, 1'b0);
    tick(30);
    check("t5 valid cycles", vcnt[1] - b1, 16);
    check("t5 bits", vbits[1][15:0], 16'h8001);
    check("t5 sync", vsync[1][15:0], 16'h8080);
    check("t5 line", lbits[1][30:0], {8'b1000_0000, 2'b11, 8'b0000_0001, 13'h1FFF});
    check("t5 line valid", lval[1][30:0], {8'hFF, 2'b00, 8'hFF, 13'h0000});

    // Five words with in_valid held high.
    b0 = vcnt[0];
    bb = bcnt[0];
    for (int i = 0; i < 5; i++) send(0, words[i], 1'b1);
    v[0] = 1'b0;
    tick(50);
    check("t6 valid cycles", vcnt[0] - b0, 40);
    check("t6 bits", vbits[0][39:0], 40'h1122334455);
    check("t6 sync", vsync[0][39:0], 40'h8080808080);
    // One cycle with only the buffer occupied, then 40 cycles of frames.
    check("t6 busy cycles", bcnt[0] - bb, 41);

    // Reset in the middle of bit 3 of FF: remaining bits are dropped.
    send(0, 8'hFF, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t1 pre-reset valid", o_valid[0], 1'b1);
    check("t1 pre-reset pcm", o_pcm[0], 1'b1);
    #1 reset = 1'b1;
    #1 check_reset("frame reset");
    @(posedge clk);
    #1 reset = 1'b0;
    b0 = vcnt[0];
    tick(12);
    check("t1 no bits after reset", vcnt[0] - b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_pcm_par2ser
`default_nettype wire
